qspi_rd_checker: RTL and testbench

- Downstream consumer of the QSPI driver's read-byte stream (read data plus byte-valid strobe). It runs in the flash test flow after page program / sector erase.
- Checks each returned byte against an expected pattern, either incrementing-from-seed or erased 0xFF. Reports pass/fail, error count and first mismatch.
- Buffers accepted bytes in a small FIFO for a downstream debug sink (UART/ILA capture).

---
 rtl/qspi_pkg.sv | 22 ++
 rtl/qspi_byte_fifo.sv | 54 +++++
 rtl/qspi_rd_checker.sv | 180 ++++++++++++++++++
 tb/tb_qspi_rd_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI read-back checker.
package qspi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StFinish
    } state_e;

    localparam logic        MODE_PATTERN       = 1'b0;
    localparam logic        MODE_BLANK         = 1'b1;
    localparam logic [7:0]  BLANK_BYTE         = 8'hFF;
    localparam int unsigned PAGE_BYTES_DEFAULT = 256;

    // Expected read-back byte for a given run mode, seed and 8-bit (wrapping) index.
    function automatic logic [7:0] expected_byte(input logic       mode,
                                                 input logic [7:0] seed,
                                                 input logic [7:0] idx);
        return (mode == MODE_BLANK) ? BLANK_BYTE : 8'(seed + idx);
    endfunction

endpackage

// File: rtl/qspi_byte_fifo.sv
// First-word-fall-through byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module qspi_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_push,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_pop,
    output logic [WIDTH-1:0] O_data,
    output logic             O_empty,
    output logic             O_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status flags and accepted push/pop; a push into a full FIFO is taken if the head leaves.
    always_comb begin
        O_empty = (wptr_q == rptr_q);
        O_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                  (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
        do_pop  = I_pop && !O_empty;
        do_push = I_push && (!O_full || do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        O_data  = mem_q[rptr_q[PTR_W-1:0]];
    end

    // Pointer state.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge I_clk) begin
        if (do_push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= I_data;
        end
    end

endmodule

// File: rtl/qspi_rd_checker.sv
// Checks the QSPI read-byte stream against an incrementing or erased pattern and
// buffers accepted bytes for a debug sink.
module qspi_rd_checker
    import qspi_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = PAGE_BYTES_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 9
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_start,
    input  logic             I_mode,
    input  logic [7:0]       I_seed,
    input  logic [CNT_W-1:0] I_byte_len,
    input  logic [7:0]       I_rd_data,
    input  logic             I_rd_valid,
    output logic             O_busy,
    output logic             O_done,
    output logic             O_pass,
    output logic [CNT_W-1:0] O_err_cnt,
    output logic [7:0]       O_first_err_idx,
    output logic [7:0]       O_first_err_data,
    output logic [7:0]       O_fifo_data,
    output logic             O_fifo_valid,
    input  logic             I_fifo_ready,
    output logic             O_overflow
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [7:0]       seed_q, seed_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [7:0]       ferr_idx_q, ferr_idx_d;
    logic [7:0]       ferr_data_q, ferr_data_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             ovf_q, ovf_d;

    logic             fifo_push;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] start_len;

    // Requested length, clamped to one page.
    always_comb begin
        start_len = (I_byte_len > CNT_W'(PAGE_BYTES)) ? CNT_W'(PAGE_BYTES) : I_byte_len;
    end

    // Next-state: run control, comparison, error capture and sticky overflow.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        len_d       = len_q;
        idx_d       = idx_q;
        err_d       = err_q;
        ferr_idx_d  = ferr_idx_q;
        ferr_data_d = ferr_data_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        ovf_d       = ovf_q;
        fifo_push   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (I_start) begin
                    mode_d      = I_mode;
                    seed_d      = I_seed;
                    len_d       = start_len;
                    idx_d       = '0;
                    err_d       = '0;
                    ferr_idx_d  = '0;
                    ferr_data_d = '0;
                    pass_d      = 1'b0;
                    ovf_d       = 1'b0;
                    if (start_len == '0) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (I_rd_valid) begin
                    fifo_push = 1'b1;
                    if (I_rd_data != expected_byte(mode_q, seed_q, idx_q[7:0])) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (err_q == '0) begin
                            ferr_idx_d  = idx_q[7:0];
                            ferr_data_d = I_rd_data;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    // Result is registered on the way into FINISH so the last byte counts.
                    if (idx_d == len_q) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The dropped byte has already been checked and counted above.
        if (fifo_push && fifo_full && !I_fifo_ready) begin
            ovf_d = 1'b1;
        end
    end

    // FSM and result registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= StIdle;
            mode_q      <= MODE_PATTERN;
            seed_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            err_q       <= '0;
            ferr_idx_q  <= '0;
            ferr_data_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            ferr_idx_q  <= ferr_idx_d;
            ferr_data_q <= ferr_data_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            ovf_q       <= ovf_d;
        end
    end

    qspi_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_push  (fifo_push),
        .I_data  (I_rd_data),
        .I_pop   (I_fifo_ready),
        .O_data  (fifo_head),
        .O_empty (fifo_empty),
        .O_full  (fifo_full)
    );

    // Output mapping; FIFO data is masked while empty so stale storage never shows.
    always_comb begin
        O_busy           = (state_q == StCheck);
        O_done           = done_q;
        O_pass           = pass_q;
        O_err_cnt        = err_q;
        O_first_err_idx  = ferr_idx_q;
        O_first_err_data = ferr_data_q;
        O_fifo_valid     = !fifo_empty;
        O_fifo_data      = fifo_empty ? 8'h00 : fifo_head;
        O_overflow       = ovf_q;
    end

endmodule

// File: tb/tb_qspi_rd_checker.sv
// Directed bench for qspi_rd_checker.
module tb_qspi_rd_checker;

    localparam int unsigned CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [7:0]       seed = '0;
    logic [CNT_W-1:0] byte_len = '0;
    logic [7:0]       rd_data = '0;
    logic             rd_valid = 1'b0;
    logic             fifo_ready = 1'b0;
    logic             busy, done, pass, fifo_valid, overflow;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       first_err_idx, first_err_data, fifo_data;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int mism;
    int done_before;
    logic [7:0] popped [$];
    logic [7:0] blank_v [8] = '{8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};

    qspi_rd_checker #(
        .PAGE_BYTES (256),
        .FIFO_DEPTH (16),
        .CNT_W      (CNT_W)
    ) dut (
        .I_clk            (clk),
        .I_rst_n          (rst_n),
        .I_start          (start),
        .I_mode           (mode),
        .I_seed           (seed),
        .I_byte_len       (byte_len),
        .I_rd_data        (rd_data),
        .I_rd_valid       (rd_valid),
        .O_busy           (busy),
        .O_done           (done),
        .O_pass           (pass),
        .O_err_cnt        (err_cnt),
        .O_first_err_idx  (first_err_idx),
        .O_first_err_data (first_err_data),
        .O_fifo_data      (fifo_data),
        .O_fifo_valid     (fifo_valid),
        .I_fifo_ready     (fifo_ready),
        .O_overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Record every byte the debug sink takes, and every done pulse.
    always @(posedge clk) begin
        if (rst_n && fifo_valid && fifo_ready) popped.push_back(fifo_data);
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic m, input logic [7:0] s, input int len);
        mode = m;
        seed = s;
        byte_len = CNT_W'(len);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        rd_data = d;
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_fifo_valid", fifo_valid, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        step();

        // Pattern pass, seed 0x10, full page, one byte every 4 cycles
        fifo_ready = 1'b1;
        popped.delete();
        arm(1'b0, 8'h10, 256);
        chk("pat_busy", busy, 1);
        for (int i = 0; i < 256; i++) begin
            feed(8'(8'h10 + i));
            if (i == 254) chk("pat_not_done_early", done, 0);
            if (i != 255) repeat (3) step();
        end
        chk("pat_done", done, 1);
        chk("pat_pass", pass, 1);
        chk("pat_err", err_cnt, 0);
        chk("pat_busy_end", busy, 0);
        step();
        chk("pat_done_pulse", done, 0);
        chk("pat_pass_held", pass, 1);
        repeat (3) step();
        chk("pat_fifo_count", popped.size(), 256);
        mism = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] !== 8'(8'h10 + i)) mism++;
        chk("pat_fifo_order", mism, 0);
        chk("pat_overflow", overflow, 0);

        // Blank check with two errors
        arm(1'b1, 8'h00, 8);
        for (int i = 0; i < 8; i++) feed(blank_v[i]);
        chk("blank_done", done, 1);
        chk("blank_pass", pass, 0);
        chk("blank_err", err_cnt, 2);
        chk("blank_first_idx", first_err_idx, 2);
        chk("blank_first_data", first_err_data, 8'h7F);
        repeat (3) step();

        // Overflow: ready held low, 20 back-to-back bytes
        fifo_ready = 1'b0;
        arm(1'b0, 8'h00, 20);
        for (int i = 0; i < 20; i++) begin
            feed(8'(i));
            if (i == 15) chk("ovf_not_yet", overflow, 0);
            if (i == 16) chk("ovf_set", overflow, 1);
        end
        chk("ovf_done", done, 1);
        chk("ovf_pass", pass, 1);
        chk("ovf_err", err_cnt, 0);
        chk("ovf_head", fifo_data, 8'h00);
        step();
        chk("ovf_sticky", overflow, 1);
        popped.delete();
        fifo_ready = 1'b1;
        repeat (18) step();
        fifo_ready = 1'b0;
        chk("ovf_fifo_count", popped.size(), 16);
        mism = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] !== 8'(i)) mism++;
        chk("ovf_fifo_order", mism, 0);

        // Full FIFO with push and pop in the same cycle keeps the byte
        popped.delete();
        arm(1'b0, 8'h00, 17);
        chk("pp_ovf_cleared", overflow, 0);
        for (int i = 0; i < 16; i++) feed(8'(i));
        fifo_ready = 1'b1;
        feed(8'd16);
        fifo_ready = 1'b0;
        chk("pp_no_overflow", overflow, 0);
        chk("pp_done", done, 1);
        chk("pp_head", fifo_data, 8'h01);
        popped.delete();
        fifo_ready = 1'b1;
        repeat (18) step();
        chk("pp_fifo_count", popped.size(), 16);
        mism = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] !== 8'(i + 1)) mism++;
        chk("pp_fifo_order", mism, 0);

        // Length zero finishes one cycle after start
        arm(1'b0, 8'h00, 0);
        chk("len0_done", done, 1);
        chk("len0_pass", pass, 1);
        chk("len0_err", err_cnt, 0);
        chk("len0_busy", busy, 0);

        // Strobes in IDLE are ignored
        step();
        rd_data = 8'h55;
        rd_valid = 1'b1;
        repeat (3) step();
        rd_valid = 1'b0;
        chk("idle_strobe_fifo", fifo_valid, 0);
        chk("idle_strobe_err", err_cnt, 0);

        // Start with a same-cycle strobe, then a second start mid-run
        popped.delete();
        rd_data = 8'h99;
        rd_valid = 1'b1;
        arm(1'b0, 8'h20, 3);
        rd_valid = 1'b0;
        chk("startv_err", err_cnt, 0);
        chk("startv_busy", busy, 1);
        feed(8'h20);
        arm(1'b1, 8'h70, 1);
        chk("restart_busy", busy, 1);
        chk("restart_err", err_cnt, 0);
        feed(8'h21);
        chk("restart_not_done", done, 0);
        feed(8'h22);
        chk("restart_done", done, 1);
        chk("restart_pass", pass, 1);
        chk("restart_err_end", err_cnt, 0);
        repeat (3) step();
        chk("restart_fifo_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("restart_fifo_b0", popped[0], 8'h20);
            chk("restart_fifo_b2", popped[2], 8'h22);
        end

        // Asynchronous reset mid-run
        fifo_ready = 1'b0;
        arm(1'b0, 8'h00, 10);
        for (int i = 0; i < 5; i++) feed((i == 1) ? 8'hAA : 8'(i));
        chk("mid_err", err_cnt, 1);
        done_before = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_first_idx", first_err_idx, 0);
        chk("mid_rst_first_data", first_err_data, 0);
        chk("mid_rst_fifo_valid", fifo_valid, 0);
        chk("mid_rst_fifo_data", fifo_data, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("mid_rst_no_done", done_cnt - done_before, 0);
        arm(1'b0, 8'h05, 2);
        feed(8'h05);
        feed(8'h06);
        chk("post_rst_done", done, 1);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_fifo_valid", fifo_valid, 1);
        chk("post_rst_head", fifo_data, 8'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
